rf_writeback_queue: RTL and testbench
=====================================

Name: rf_writeback_queue

Overview:
- Write-side companion to the three-ported register file. Collects writeback results from the datapath and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file write port (we3/wa3/wd3).
- Provides read-side bypass: a read of a register with a pending write returns the newest buffered value, not the stale file contents.
- Sits between the execute/memory result path and the register file.

Parameters:
- DEPTH, 4, number of buffered write entries (power of two, >=2)
- DW, 32, data width
- AW, 5, register address width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  writeback request present
- in_ready  output  1  queue can accept the request this cycle
- in_addr  input  AW  destination register
- in_data  input  DW  writeback value
- drain_en  input  1  register file write port available this cycle
- rf_we  output  1  drives we3
- rf_wa  output  AW  drives wa3
- rf_wd  output  DW  drives wd3
- ra1, ra2  input  AW  read addresses, in parallel with RD1/RD2
- hit1, hit2  output  1  pending write exists for ra1/ra2
- fwd1, fwd2  output  DW  newest pending data for ra1/ra2
- count  output  $clog2(DEPTH)+1  occupied entries
- empty, full  output  1  status

Behaviour:
- Reset (synchronous, CLK edge with reset=1):
  - count=0, empty=1, full=0.
  - Head and tail pointers=0; all entry valid bits cleared.
  - rf_we=0, hit1=hit2=0.
  - reset overrides any simultaneous push or pop.
- Push:
  - push = in_valid & in_ready & (in_addr != 0).
  - Entry written at tail on the edge; tail increments modulo DEPTH.
- Register 0:
  - in_valid with in_addr==0 completes the handshake when in_ready=1.
  - The request is discarded: no entry written, count unchanged.
- in_ready = !full | pop. A push while full is legal when a pop occurs in the same cycle.
- Drain (combinational from state):
  - rf_we = !empty & drain_en.
  - rf_wa/rf_wd = head entry. When empty, rf_wa=0 and rf_wd=0.
  - pop = rf_we. Head advances on the same edge that the register file captures the write.
- Latency:
  - A request accepted at edge N is at the head no earlier than the cycle after edge N. No fall-through.
  - On an empty queue with drain_en held at 1, rf_we=1 in the cycle following acceptance and the register file updates at edge N+1.
- Ordering: strict FIFO. Multiple entries to the same register drain oldest-first, so the file ends with the newest value.
- Count:
  - push only: +1. Pop only: -1. Both or neither: unchanged.
  - full = (count==DEPTH); empty = (count==0).
- Pointer wrap-around: modulo DEPTH. Occupancy is derived from count, never from pointer equality alone.
- Bypass (combinational):
  - For each read port, search all valid entries, including the head being drained this cycle.
  - hitX=1 if any valid entry matches raX and raX != 0.
  - fwdX = data of the youngest matching entry, by age order from tail backward; 0 when no hit.
  - An entry being popped this cycle still forwards. After the edge the file holds that value, so the result stays consistent.
  - An entry being pushed this cycle is not visible until the next cycle.
- drain_en=0 holds the head; the queue may fill. When full with drain_en=0, in_ready=0 and the request must be held by the source.
- Reset mid-operation: all pending entries are discarded (not written to the register file). rf_we=0 in the cycle after reset.

Test Plan:
- Reset with 3 entries pending -> next cycle: count=0, empty=1, rf_we=0, hit1=0; register file unchanged.
- Push (addr=5, data=0xDEADBEEF) at edge 1, drain_en=1 -> cycle 2: rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; ra1=5 gives hit1=1, fwd1=0xDEADBEEF; after edge 2: empty=1, and the register file reads 0xDEADBEEF.
- drain_en=0; push addr 8 with data 1, 2, 3 in order; ra2=8 -> hit2=1, fwd2=3; then drain_en=1 -> three writes in order 1, 2, 3; final register file value of $8 is 3.
- drain_en=0; push DEPTH=4 entries -> full=1, in_ready=0; then drain_en=1 with in_valid=1 -> in_ready=1; push and pop on the same edge; count stays 4.
- Push addr=0, data=0x1234 -> handshake completes, count unchanged, rf_we never asserted; ra1=0 gives hit1=0.
- Random mix of 200 pushes with random drain_en -> write order at the register file port matches the reference FIFO model; every read of a pending address matches the model's newest value; pointers wrap at least 40 times.

Source files
------------

// File: rtl/rf_writeback_queue.sv
// Writeback FIFO in front of the three-ported register file: buffers results,
// drains one per cycle onto we3/wa3/wd3, and forwards pending data to readers.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wa,
    output logic [DW-1:0]            rf_wd,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic             push;
    logic             pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign rf_we    = !empty && drain_en;
    assign pop      = rf_we;
    assign in_ready = !full || pop;
    // Register-0 requests still handshake but never occupy an entry.
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign rf_wa    = empty ? '0 : ent_addr[head];
    assign rf_wd    = empty ? '0 : ent_data[head];

    always_ff @(posedge CLK) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            // On a full push+pop head==tail, so the set below must win over the clear.
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            ent_addr[tail] <= in_addr;
            ent_data[tail] <= in_data;
        end
    end

    // Walk oldest to youngest from head so the last match is the newest value.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] ra);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (vld[idx] && (ent_addr[idx] == ra) && (ra != '0))
                r = {1'b1, ent_data[idx]};
        end
        return r;
    endfunction

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        {hit1, fwd1} = lookup(ra1);
        {hit2, fwd2} = lookup(ra2);
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: stimulus pushes expected writes,
// a negedge monitor checks drain order, bypass and status against them.
module tb_rf_writeback_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          CLK;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic [2:0]    count;
    logic          empty;
    logic          full;

    ent_t          exp_q[$];
    int            n_cmp  = 0;
    int            n_bad  = 0;
    int            pops   = 0;
    int            n_push = 0;
    bit            mon_en = 0;
    logic [DW-1:0] rf_mem [32];

    rf_writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .ra1(ra1), .ra2(ra2),
        .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count), .empty(empty), .full(full)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for the register file, written only from the DUT's write port.
    always @(posedge CLK) if (rf_we === 1'b1) rf_mem[rf_wa] <= rf_wd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic          h1, h2, we_e;
        logic [DW-1:0] f1, f2;
        ent_t          e;
        if (mon_en) begin
            h1 = 1'b0; h2 = 1'b0; f1 = '0; f2 = '0;
            foreach (exp_q[i]) begin
                if (ra1 != '0 && exp_q[i].a == ra1) begin h1 = 1'b1; f1 = exp_q[i].d; end
                if (ra2 != '0 && exp_q[i].a == ra2) begin h2 = 1'b1; f2 = exp_q[i].d; end
            end
            chk("count", DW'(count), DW'(exp_q.size()));
            chk("empty", DW'(empty), DW'(exp_q.size() == 0));
            chk("full",  DW'(full),  DW'(exp_q.size() == DEPTH));
            chk("hit1", DW'(hit1), DW'(h1));
            chk("fwd1", fwd1, f1);
            chk("hit2", DW'(hit2), DW'(h2));
            chk("fwd2", fwd2, f2);
            we_e = (exp_q.size() > 0) && drain_en;
            chk("rf_we", DW'(rf_we), DW'(we_e));
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_write: got wa=%0h wd=%0h expected no write", rf_wa, rf_wd);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_wa", DW'(rf_wa), DW'(e.a));
                    chk("rf_wd", rf_wd, e.d);
                    pops++;
                end
            end else if (exp_q.size() == 0) begin
                chk("idle_wa", DW'(rf_wa), '0);
                chk("idle_wd", rf_wd, '0);
            end
        end
    end

    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic de, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic rst);
        in_valid = v; in_addr = a; in_data = d; drain_en = de;
        ra1 = r1; ra2 = r2; reset = rst;
        @(negedge CLK);
        #1;
        if (mon_en) chk("in_ready", DW'(in_ready), DW'(exp_q.size() < DEPTH));
        if (rst) exp_q.delete();
        else if (v && exp_q.size() < DEPTH && a != '0) begin
            exp_q.push_back({a, d});
            n_push++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step(1'b0, '0, '0, 1'b1, '0, '0, 1'b0);
        end
        chk("drained_empty", DW'(empty), 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        mon_en = 1;
        drain_en = 1'b1;
        #1;
        chk("rst_count", DW'(count), 0);
        chk("rst_empty", DW'(empty), 1);
        chk("rst_full",  DW'(full),  0);
        chk("rst_we",    DW'(rf_we), 0);

        // Reset with three entries pending
        for (int i = 1; i <= 3; i++) step(1'b1, AW'(i), DW'(32'h100 + i), 1'b0, 5'd1, '0, 1'b0);
        chk("pend_count", DW'(count), 3);
        step(1'b0, '0, '0, 1'b0, 5'd1, '0, 1'b1);
        drain_en = 1'b1;
        #1;
        chk("mid_rst_count", DW'(count), 0);
        chk("mid_rst_empty", DW'(empty), 1);
        chk("mid_rst_we",    DW'(rf_we), 0);
        chk("mid_rst_hit1",  DW'(hit1),  0);
        chk("mid_rst_rf1",   rf_mem[1],  0);
        chk("mid_rst_rf3",   rf_mem[3],  0);

        // Single write, one-cycle latency to the file
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, '0, 1'b0);
        chk("t2_we",   DW'(rf_we), 1);
        chk("t2_wa",   DW'(rf_wa), 5);
        chk("t2_wd",   rf_wd, 32'hDEADBEEF);
        chk("t2_hit1", DW'(hit1), 1);
        chk("t2_fwd1", fwd1, 32'hDEADBEEF);
        step(1'b0, '0, '0, 1'b1, 5'd5, '0, 1'b0);
        chk("t2_empty", DW'(empty), 1);
        chk("t2_rf5",   rf_mem[5], 32'hDEADBEEF);
        chk("t2_hit1_after", DW'(hit1), 0);

        // Same register three times: newest forwards, oldest drains first
        for (int i = 1; i <= 3; i++) step(1'b1, 5'd8, DW'(i), 1'b0, '0, 5'd8, 1'b0);
        chk("t3_hit2", DW'(hit2), 1);
        chk("t3_fwd2", fwd2, 3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, '0, 5'd8, 1'b0);
        chk("t3_rf8", rf_mem[8], 3);
        chk("t3_empty", DW'(empty), 1);

        // Fill, then push and pop on the same edge
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(10 + i), DW'(32'hA0 + i), 1'b0, '0, '0, 1'b0);
        in_valid = 1'b1; in_addr = 5'd14; in_data = 32'hE; drain_en = 1'b0;
        #1;
        chk("t4_full",     DW'(full),     1);
        chk("t4_ready_lo", DW'(in_ready), 0);
        drain_en = 1'b1;
        #1;
        chk("t4_ready_hi", DW'(in_ready), 1);
        step(1'b1, 5'd14, 32'hE, 1'b1, 5'd14, '0, 1'b0);
        chk("t4_count", DW'(count), 4);
        drain_all();
        chk("t4_rf14", rf_mem[14], 32'hE);

        // Register 0 is discarded
        step(1'b1, '0, 32'h1234, 1'b1, '0, '0, 1'b0);
        chk("t5_count", DW'(count), 0);
        chk("t5_we",    DW'(rf_we), 0);
        chk("t5_hit1",  DW'(hit1),  0);

        // Random mix against the scoreboard
        n_push = 0;
        for (int c = 0; c < 5000 && n_push < 200; c++) begin
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), 1'b0);
        end
        chk("rand_pushes", DW'(n_push >= 200), 1);
        drain_all();
        chk("wraps", DW'(pops / DEPTH >= 40), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
